welcome_scanout: RTL and testbench
==================================

// Module: welcome_scanout
// PURPOSE
//  Scans out the 640x480 1-bpp welcome bitmap to VGA. Sits directly downstream of the welcome
//  frame RAM: drives its read address from the VGA controller's DrawX/DrawY and consumes its
//  registered 1-bit data_Out. Produces pipeline-aligned RGB and sync signals.
//  Runs a per-frame fade-in / hold / fade-out sequence, and reports when the welcome screen is done.
// PARAMETERS
//  H_ACTIVE   640    visible pixels per line
//  V_ACTIVE   480    visible lines per frame
//  ADDR_W     19     RAM address width (H_ACTIVE*V_ACTIVE <= 2**ADDR_W)
//  FADE_STEP  8      intensity change per frame (1..256)
//  FG_R/G/B   8'hFF  foreground colour at full intensity
// PORTS
//  Clk           in   1       pixel clock; single clock domain
//  Reset_n       in   1       asynchronous, active-low reset
//  DrawX         in   10      current pixel column from VGA controller
//  DrawY         in   10      current pixel row from VGA controller
//  blank_in      in   1       VGA blank, active-low (0 = blanking)
//  hs_in, vs_in  in   1       horizontal / vertical sync, active-low
//  start_key     in   1       start request, active-high level, asynchronous to Clk
//  ram_data      in   1       RAM read data (1-cycle registered read)
//  read_address  out  ADDR_W  RAM read address
//  Red/Green/Blue out 8       pixel colour
//  hs_out, vs_out, blank_out out 1   syncs and blank delayed to align with RGB
//  welcome_done  out  1       high when the fade-out has completed
// BEHAVIOUR
//  Reset (async, Reset_n=0): read_address=0, RGB=0, hs_out=vs_out=1, blank_out=0,
//   welcome_done=0, level=0, state=FADE_IN, sync/edge flops cleared.
//  Address (stage 1, registered):
//   - read_address = DrawY*640 + DrawX, built from shifts (Y<<9)+(Y<<7)+X; no multiplier.
//   - in_rng = (DrawX<H_ACTIVE && DrawY<V_ACTIVE); when in_rng=0, read_address=0.
//  Pipeline: T0 DrawX/Y present; T1 read_address registered; T2 ram_data valid; T3 RGB registered.
//   - in_rng, blank_in, hs_in and vs_in are delayed by exactly 3 flops each, so outputs align.
//  Colour (stage 3):
//   - pix = ram_data & in_rng_d2 & blank_in_d2.
//   - pix=1: C_out = (FG_C * level) >> 8 per channel; 8x9-bit product, result truncated to 8 bits.
//   - pix=0: C_out = 0.
//  Frame tick: one-cycle pulse on falling edge of vs_in (registered prev-value compare).
//  Intensity level: 9-bit, range 0..256; level 256 gives exact FG colour.
//   - level changes only on a frame tick, never mid-frame.
//   - saturates at both ends (no wrap); e.g. level 250 + step 8 -> 256, level 5 - 8 -> 0.
//  start_key: 2-flop synchroniser, then rising-edge detect -> 1-cycle start_pulse.
//  FSM (state changes on the clock edge):
//   - FADE_IN:  on tick level+=FADE_STEP; level reaches 256 -> SHOW.
//               start_pulse -> FADE_OUT (from current level).
//   - SHOW:     level held at 256; start_pulse -> FADE_OUT.
//   - FADE_OUT: on tick level-=FADE_STEP; level reaches 0 -> DONE. start_pulse ignored.
//   - DONE:     welcome_done=1 (registered, held); level=0; exits only on reset.
//  Simultaneous tick and start_pulse in FADE_IN: the state goes to FADE_OUT; the level is not
//   incremented on that tick.
//  Reset mid-frame or mid-fade: everything returns to its reset values at once; the pipeline
//   flushes (blank_out=0 for 3 cycles after release).
//  Address generation and sync delays run in every state, including DONE.
// TESTING
//  1. Hold Reset_n=0 -> RGB=0, read_address=0, hs_out=vs_out=1, welcome_done=0.
//     Release -> state FADE_IN, level 0.
//  2. DrawX=5, DrawY=2, blank_in=1 -> read_address=1285 one cycle later.
//     DrawX=639, DrawY=479 -> 307199. DrawX=700 -> 0 and RGB=0 three cycles later.
//  3. Force level=256 (SHOW), ram_data=1 at T2 for a pixel presented at T0 -> RGB=FF/FF/FF at T3.
//     hs_out/vs_out/blank_out are equal to inputs delayed 3 cycles.
//  4. FADE_STEP=8, apply 32 vs_in falling edges -> level 8,16,...,256, state SHOW after tick 32.
//     Tick 16 -> level 128, Red=0x7F.
//  5. In SHOW, pulse start_key for 3 cycles -> exactly one start_pulse, FADE_OUT.
//     After 32 ticks level=0 and welcome_done=1, held through further ticks and start_key presses.
//  6. start_key on same cycle as tick in FADE_IN at level 64 -> FADE_OUT, level stays 64.
//     Reset_n low mid-FADE_OUT -> all reset values.

Source files
------------

// File: rtl/welcome_scanout.sv
// -----------------------------------------------------------------------------
// welcome_scanout
//   Scans the 640x480 1-bpp welcome bitmap out of the welcome frame RAM to VGA.
//   It generates the RAM read address from DrawX/DrawY and applies a per-frame
//   fade-in / hold / fade-out intensity to the foreground colour. It raises
//   welcome_done once the fade-out has finished.
//
//   Pipeline: T0 DrawX/DrawY present, T1 read_address registered,
//             T2 ram_data valid, T3 RGB / syncs / blank registered.
//
// Ports
//   Clk            in   pixel clock (single domain)
//   Reset_n        in   asynchronous active-low reset
//   DrawX, DrawY   in   current pixel column / row from the VGA controller
//   blank_in       in   VGA blank, active-low (0 = blanking)
//   hs_in, vs_in   in   horizontal / vertical sync, active-low
//   start_key      in   start request, active-high level, asynchronous
//   ram_data       in   RAM read data (1-cycle registered read)
//   read_address   out  RAM read address
//   Red/Green/Blue out  pixel colour
//   hs_out, vs_out, blank_out out  syncs and blank aligned with RGB
//   welcome_done   out  high (held) once the fade-out has completed
// -----------------------------------------------------------------------------
module welcome_scanout #(
   parameter int         H_ACTIVE  = 640,
   parameter int         V_ACTIVE  = 480,
   parameter int         ADDR_W    = 19,
   parameter int         FADE_STEP = 8,
   parameter logic [7:0] FG_R      = 8'hFF,
   parameter logic [7:0] FG_G      = 8'hFF,
   parameter logic [7:0] FG_B      = 8'hFF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank_in,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic              start_key,
   input  logic              ram_data,
   output logic [ADDR_W-1:0] read_address,
   output logic [7:0]        Red,
   output logic [7:0]        Green,
   output logic [7:0]        Blue,
   output logic              hs_out,
   output logic              vs_out,
   output logic              blank_out,
   output logic              welcome_done
);

   typedef enum logic [1:0] {
      S_FADE_IN  = 2'd0,
      S_SHOW     = 2'd1,
      S_FADE_OUT = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   localparam logic [8:0] LVL_FULL = 9'd256;
   localparam logic [8:0] STEP9    = 9'(FADE_STEP);
   localparam logic [9:0] STEP10   = 10'(FADE_STEP);

   // Channel scaling: 8x9-bit product, keep bits [15:8].
   function automatic logic [7:0] scale_colour(input logic [7:0] c, input logic [8:0] lvl);
      logic [16:0] prod;
      prod = {9'd0, c} * {8'd0, lvl};
      return 8'(prod >> 8);
   endfunction

   // ---------------- stage 1: address ----------------
   logic              in_rng_s;
   logic [ADDR_W-1:0] addr_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] y_ext_s;
   logic [ADDR_W-1:0] x_ext_s;

   // Address computation: Y*640 as (Y<<9)+(Y<<7), forced to 0 off-screen.
   always_comb begin
      y_ext_s  = ADDR_W'(DrawY);
      x_ext_s  = ADDR_W'(DrawX);
      in_rng_s = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
      if (in_rng_s) begin
         addr_d = (y_ext_s << 9) + (y_ext_s << 7) + x_ext_s;
      end else begin
         addr_d = {ADDR_W{1'b0}};
      end
   end

   // ---------------- delay lines (T1, T2) ----------------
   logic [1:0] in_rng_q;
   logic [1:0] blank_q;
   logic [1:0] hs_q;
   logic [1:0] vs_q;

   // Address register and the first two taps of each alignment delay.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q   <= {ADDR_W{1'b0}};
         in_rng_q <= 2'b00;
         blank_q  <= 2'b00;
         hs_q     <= 2'b11;
         vs_q     <= 2'b11;
      end else begin
         addr_q   <= addr_d;
         in_rng_q <= {in_rng_q[0], in_rng_s};
         blank_q  <= {blank_q[0], blank_in};
         hs_q     <= {hs_q[0], hs_in};
         vs_q     <= {vs_q[0], vs_in};
      end
   end

   // ---------------- frame tick and start synchroniser ----------------
   logic vs_prev_q;
   logic key_s1_q;
   logic key_s2_q;
   logic key_s3_q;
   logic tick_s;
   logic start_pulse_s;

   // vs_in history for the falling-edge tick; start_key synchroniser plus edge flop.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_prev_q <= 1'b0;
         key_s1_q  <= 1'b0;
         key_s2_q  <= 1'b0;
         key_s3_q  <= 1'b0;
      end else begin
         vs_prev_q <= vs_in;
         key_s1_q  <= start_key;
         key_s2_q  <= key_s1_q;
         key_s3_q  <= key_s2_q;
      end
   end

   assign tick_s        = vs_prev_q & ~vs_in;
   assign start_pulse_s = key_s2_q & ~key_s3_q;

   // ---------------- fade FSM ----------------
   state_t     state_q;
   state_t     state_d;
   logic [8:0] level_q;
   logic [8:0] level_d;
   logic [9:0] sum_s;
   logic [8:0] lvl_up_s;
   logic [8:0] lvl_dn_s;
   logic       done_q;

   // Saturating level arithmetic; the 10-bit sum keeps the carry for the 256 clamp.
   always_comb begin
      sum_s = {1'b0, level_q} + STEP10;
      if (sum_s >= 10'd256) begin
         lvl_up_s = LVL_FULL;
      end else begin
         lvl_up_s = sum_s[8:0];
      end
      if (level_q <= STEP9) begin
         lvl_dn_s = 9'd0;
      end else begin
         lvl_dn_s = level_q - STEP9;
      end
   end

   // Next state and level; a start pulse in FADE_IN wins over a coincident tick.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         S_FADE_IN: begin
            if (start_pulse_s) begin
               state_d = S_FADE_OUT;
            end else if (tick_s) begin
               level_d = lvl_up_s;
               if (lvl_up_s == LVL_FULL) begin
                  state_d = S_SHOW;
               end else begin
                  state_d = S_FADE_IN;
               end
            end else begin
               level_d = level_q;
            end
         end
         S_SHOW: begin
            level_d = LVL_FULL;
            if (start_pulse_s) begin
               state_d = S_FADE_OUT;
            end else begin
               state_d = S_SHOW;
            end
         end
         S_FADE_OUT: begin
            if (tick_s) begin
               level_d = lvl_dn_s;
               if (lvl_dn_s == 9'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FADE_OUT;
               end
            end else begin
               level_d = level_q;
            end
         end
         S_DONE: begin
            level_d = 9'd0;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_FADE_IN;
            level_d = 9'd0;
         end
      endcase
   end

   // FSM state, level and the held done flag.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_FADE_IN;
         level_q <= 9'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         done_q  <= (state_d == S_DONE);
      end
   end

   // ---------------- stage 3: colour and aligned syncs ----------------
   logic       pix_s;
   logic [7:0] red_q;
   logic [7:0] green_q;
   logic [7:0] blue_q;
   logic       hs_out_q;
   logic       vs_out_q;
   logic       blank_out_q;

   assign pix_s = ram_data & in_rng_q[1] & blank_q[1];

   // Output register: scaled foreground where the bitmap is lit, black elsewhere.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         red_q       <= 8'd0;
         green_q     <= 8'd0;
         blue_q      <= 8'd0;
         hs_out_q    <= 1'b1;
         vs_out_q    <= 1'b1;
         blank_out_q <= 1'b0;
      end else begin
         if (pix_s) begin
            red_q   <= scale_colour(FG_R, level_q);
            green_q <= scale_colour(FG_G, level_q);
            blue_q  <= scale_colour(FG_B, level_q);
         end else begin
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
         end
         hs_out_q    <= hs_q[1];
         vs_out_q    <= vs_q[1];
         blank_out_q <= blank_q[1];
      end
   end

   assign read_address = addr_q;
   assign Red          = red_q;
   assign Green        = green_q;
   assign Blue         = blue_q;
   assign hs_out       = hs_out_q;
   assign vs_out       = vs_out_q;
   assign blank_out    = blank_out_q;
   assign welcome_done = done_q;

endmodule

// File: tb/tb_welcome_scanout.sv
// Scoreboard bench for welcome_scanout: the driver pushes expectations,
// and a negedge monitor pops and compares them when they fall due.
module tb_welcome_scanout;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [9:0]  DrawX = 10'd0;
   logic [9:0]  DrawY = 10'd0;
   logic        blank_in = 1'b1;
   logic        hs_in = 1'b1;
   logic        vs_in = 1'b1;
   logic        start_key = 1'b0;
   logic        ram_data = 1'b0;
   logic [18:0] read_address;
   logic [7:0]  Red, Green, Blue;
   logic        hs_out, vs_out, blank_out, welcome_done;

   welcome_scanout dut (
      .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in), .start_key(start_key),
      .ram_data(ram_data), .read_address(read_address),
      .Red(Red), .Green(Green), .Blue(Blue),
      .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
      .welcome_done(welcome_done)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // Welcome bitmap content used by the RAM model.
   function automatic logic mem_bit(input logic [18:0] a);
      return a[0] ^ a[3] ^ a[8] ^ a[13];
   endfunction

   // Frame RAM model with registered read.
   always @(posedge Clk) ram_data <= mem_bit(read_address);

   typedef struct { int due; logic [18:0] addr; } aexp_t;
   typedef struct { int due; logic [7:0] rgb; logic hs; logic vs; logic blank;
                    logic done; bit chk_done; } oexp_t;
   aexp_t aq[$];
   oexp_t oq[$];

   int checks = 0;
   int errors = 0;

   // Reference model: fade level 0..256 and phase 0=fade-in 1=show 2=fade-out 3=done.
   int m_level = 0;
   int m_phase = 0;

   function automatic void m_tick();
      if (m_phase == 0) begin
         m_level = (m_level + 8 > 256) ? 256 : m_level + 8;
         if (m_level == 256) m_phase = 1;
      end else if (m_phase == 2) begin
         m_level = (m_level - 8 < 0) ? 0 : m_level - 8;
         if (m_level == 0) m_phase = 3;
      end else if (m_phase == 3) begin
         m_level = 0;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Apply one pixel and push its expected address and output.
   task automatic drive(input int x, input int y, input bit bl, input bit hs,
                        input bit vs, input bit key, input bit cd);
      aexp_t a;
      oexp_t o;
      bit    inr;
      int    ea;
      @(posedge Clk);
      #2;
      DrawX = 10'(x); DrawY = 10'(y); blank_in = bl; hs_in = hs; vs_in = vs;
      start_key = key;
      inr = (x < 640) && (y < 480);
      ea  = inr ? (y * 640 + x) : 0;
      a.due = cyc + 1; a.addr = 19'(ea);
      aq.push_back(a);
      o.due = cyc + 3;
      o.rgb = (inr && bl && mem_bit(19'(ea))) ? 8'((255 * m_level) / 256) : 8'd0;
      o.hs = hs; o.vs = vs; o.blank = bl;
      o.done = (m_phase == 3); o.chk_done = cd;
      oq.push_back(o);
   endtask

   task automatic idle(input bit vs, input bit key);
      drive(700, 0, 1'b1, 1'b1, vs, key, 1'b0);
   endtask

   task automatic frame_tick();
      idle(1'b1, 1'b0); idle(1'b1, 1'b0);
      idle(1'b0, 1'b0); idle(1'b1, 1'b0);
      m_tick();
      idle(1'b1, 1'b0); idle(1'b1, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) frame_tick();
   endtask

   task automatic press_start();
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
      if (m_phase == 0 || m_phase == 1) m_phase = 2;
      for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
   endtask

   // start_key timed so its synchronised pulse coincides with the vs_in tick.
   task automatic press_with_tick();
      idle(1'b1, 1'b1); idle(1'b1, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b1, 1'b0);
      if (m_phase == 0 || m_phase == 1) m_phase = 2;
      else m_tick();
      for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
   endtask

   task automatic check_pixels(input int n);
      for (int i = 0; i < n; i++)
         drive($urandom_range(639, 0), $urandom_range(479, 0), 1'b1,
               1'($urandom_range(1, 0)), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic rand_pixels(input int n);
      for (int i = 0; i < n; i++)
         drive($urandom_range(799, 0), $urandom_range(524, 0),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic reset_checks();
      chk("rst_addr", int'(read_address), 0);
      chk("rst_rgb", int'({Red, Green, Blue}), 0);
      chk("rst_hs_vs", int'({hs_out, vs_out}), 3);
      chk("rst_blank", int'(blank_out), 0);
      chk("rst_done", int'(welcome_done), 0);
   endtask

   task automatic do_reset();
      @(posedge Clk);
      #2;
      blank_in = 1'b1; DrawX = 10'd5; DrawY = 10'd2; start_key = 1'b0; vs_in = 1'b1;
      Reset_n = 1'b0;
      #1;
      reset_checks();
      aq.delete(); oq.delete();
      m_level = 0; m_phase = 0;
      repeat (2) @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      // Pipeline flush: blank_out stays low while the delay line refills.
      @(negedge Clk); chk("flush_blank1", int'(blank_out), 0);
      @(negedge Clk); chk("flush_blank2", int'(blank_out), 0);
   endtask

   // Monitor: pop and compare every expectation whose due cycle has arrived.
   always @(negedge Clk) begin : monitor
      aexp_t a;
      oexp_t o;
      if (Reset_n) begin
         while (aq.size() > 0 && aq[0].due <= cyc) begin
            a = aq.pop_front();
            checks++;
            if (a.due != cyc || read_address !== a.addr) begin
               errors++;
               $display("FAIL addr cyc=%0d got=%0d expected=%0d", cyc, read_address, a.addr);
            end
         end
         while (oq.size() > 0 && oq[0].due <= cyc) begin
            o = oq.pop_front();
            checks++;
            if (o.due != cyc || Red !== o.rgb || Green !== o.rgb || Blue !== o.rgb ||
                hs_out !== o.hs || vs_out !== o.vs || blank_out !== o.blank ||
                (o.chk_done && welcome_done !== o.done)) begin
               errors++;
               $display("FAIL out cyc=%0d got rgb=%h/%h/%h hs=%b vs=%b bl=%b done=%b expected rgb=%h hs=%b vs=%b bl=%b done=%b",
                        cyc, Red, Green, Blue, hs_out, vs_out, blank_out, welcome_done,
                        o.rgb, o.hs, o.vs, o.blank, o.done);
            end
         end
      end
   end

   initial begin
      Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      reset_checks();
      Reset_n = 1'b1;
      @(negedge Clk); chk("flush_blank0", int'(blank_out), 0);

      // Address corners and off-screen pixels at level 0.
      drive(5, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(639, 479, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(700, 10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(640, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(0, 480, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      rand_pixels(150);

      ticks(16);           // level 128 -> Red 0x7F on lit pixels
      check_pixels(16);
      ticks(16);           // level 256, SHOW
      check_pixels(16);
      rand_pixels(40);
      frame_tick();        // SHOW holds 256
      check_pixels(8);

      press_start();       // FADE_OUT from 256
      check_pixels(4);
      frame_tick();        // 248
      check_pixels(8);
      ticks(31);           // 0, DONE
      check_pixels(8);
      frame_tick();
      press_start();
      check_pixels(8);

      do_reset();
      check_pixels(4);
      ticks(8);            // level 64
      check_pixels(8);
      press_with_tick();   // FADE_OUT, level stays 64
      check_pixels(8);
      frame_tick();        // 56
      check_pixels(8);
      frame_tick();        // 48, then reset mid fade-out
      do_reset();
      check_pixels(6);

      repeat (6) @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (aq.size() != 0 || oq.size() != 0) begin
         errors++;
         $display("FAIL drain pending addr=%0d out=%0d expected=0", aq.size(), oq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
